// File: rtl/video_line_fetcher.sv
// Video line fetcher: reads one scanline from the SDRAM arbiter video port in fixed bursts into a show-ahead FIFO.
// Define VIDEO_FETCH_STATS_EN to add the saturating underflow_cnt_o counter.
module video_line_fetcher #(
  parameter int WORDS_PER_LINE = 320,
  parameter int BURST_LEN      = 8,
  parameter int FIFO_DEPTH     = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        line_start_i,
  input  logic [23:0] line_base_i,
  output logic        busy_o,
  output logic        video_sdram_rd,
  output logic [23:0] video_sdram_addr_x16,
  input  logic        video_sdram_rdy,
  input  logic        video_sdram_resp_valid,
  input  logic [15:0] video_sdram_rdata,
  output logic        video_sdram_ack,
  input  logic        pix_pop_i,
  output logic [15:0] pix_data_o,
  output logic        pix_empty_o,
  output logic        underflow_o,
  output logic        overrun_o
`ifdef VIDEO_FETCH_STATS_EN
  ,
  output logic [15:0] underflow_cnt_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int RW = $clog2(WORDS_PER_LINE + 1);

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   FILL_MAX = (AW+1)'(FIFO_DEPTH - BURST_LEN);
  localparam logic [CW-1:0] BURST_W  = CW'(BURST_LEN);
  localparam logic [RW-1:0] LINE_W   = RW'(WORDS_PER_LINE);
  localparam logic [RW-1:0] BURST_RW = RW'(BURST_LEN);
  localparam logic [23:0]   BURST_A  = 24'(BURST_LEN);

  typedef enum logic [2:0] {IDLE, WAIT_SPACE, REQ, DATA, ACK} state_t;

  state_t        state_q;
  logic          rd_q, ack_q, busy_q, underflow_q, overrun_q;
  logic [23:0]   addr_q;
  logic [RW-1:0] remaining_q;
  logic [CW-1:0] wcnt_q, wcnt_next;
  logic          pend_q;
  logic [23:0]   pend_base_q, pend_base;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wptr_q, rptr_q, fill;
  logic          empty, full, pop, pop_empty;
  logic          rx_state, accept, push, done, pend_v, restart, flush;

  assign fill      = wptr_q - rptr_q;
  assign empty     = (fill == '0);
  assign full      = (fill == DEPTH_W);
  assign pop       = pix_pop_i && !empty;
  assign pop_empty = pix_pop_i && empty;

  // Response words count in REQ (including the rdy cycle) and DATA; extras past one burst are dropped.
  assign rx_state  = (state_q == REQ) || (state_q == DATA);
  assign accept    = rx_state && video_sdram_resp_valid && (wcnt_q < BURST_W);
  assign push      = accept && (!full || pop);
  assign wcnt_next = wcnt_q + CW'(accept);
  assign done      = (wcnt_next == BURST_W);

  // A pending restart is taken at the first burst boundary; a same-cycle line_start_i wins.
  assign pend_v    = pend_q || line_start_i;
  assign pend_base = line_start_i ? line_base_i : pend_base_q;
  assign restart   = ((state_q == ACK) || (state_q == WAIT_SPACE)) && pend_v;
  assign flush     = ((state_q == IDLE) && line_start_i) || restart;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define what is valid, so reset stays off the RAM.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_q[AW-1:0]] <= video_sdram_rdata;
  end

  assign pix_data_o  = empty ? 16'h0000 : mem[rptr_q[AW-1:0]];
  assign pix_empty_o = empty;

  // NOTE: state uses non-blocking assignments only, so later defaults-then-overrides within the block are safe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rd_q        <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      wcnt_q      <= '0;
      pend_q      <= 1'b0;
      pend_base_q <= '0;
      underflow_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      wcnt_q <= wcnt_next;
      if (pop_empty) underflow_q <= 1'b1;
      if (line_start_i && (state_q != IDLE)) overrun_q <= 1'b1;
      if (line_start_i && rx_state) begin
        pend_q      <= 1'b1;
        pend_base_q <= line_base_i;
      end
      case (state_q)
        IDLE: begin
          if (line_start_i) begin
            addr_q      <= line_base_i;
            remaining_q <= LINE_W;
            pend_q      <= 1'b0;
            underflow_q <= pop_empty;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= WAIT_SPACE;
          end
        end
        WAIT_SPACE: begin
          if (restart) begin
            addr_q      <= pend_base;
            remaining_q <= LINE_W;
            pend_q      <= 1'b0;
          end else if (fill <= FILL_MAX) begin
            rd_q    <= 1'b1;
            wcnt_q  <= '0;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (video_sdram_rdy) begin
            if (done) begin
              rd_q    <= 1'b0;
              ack_q   <= 1'b1;
              state_q <= ACK;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (done) begin
            rd_q    <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= ACK;
          end
        end
        ACK: begin
          if (restart) begin
            addr_q      <= pend_base;
            remaining_q <= LINE_W;
            pend_q      <= 1'b0;
            state_q     <= WAIT_SPACE;
          end else begin
            addr_q      <= addr_q + BURST_A;
            remaining_q <= remaining_q - BURST_RW;
            if (remaining_q == BURST_RW) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              state_q <= WAIT_SPACE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o               = busy_q;
  assign video_sdram_rd       = rd_q;
  assign video_sdram_ack      = ack_q;
  assign video_sdram_addr_x16 = addr_q;
  assign underflow_o          = underflow_q;
  assign overrun_o            = overrun_q;

`ifdef VIDEO_FETCH_STATS_EN
  logic [15:0] ucnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ucnt_q <= '0;
    else if (pop_empty && (ucnt_q != 16'hFFFF)) ucnt_q <= ucnt_q + 16'd1;
  end

  assign underflow_cnt_o = ucnt_q;
`endif

endmodule

// File: tb/tb_video_line_fetcher.sv
// Randomized bench for video_line_fetcher: SDRAM responder plus a queue model of the line FIFO and burst addresses.
module tb_video_line_fetcher;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        line_start_i;
  logic [23:0] line_base_i;
  logic        busy_o;
  logic        video_sdram_rd;
  logic [23:0] video_sdram_addr_x16;
  logic        video_sdram_rdy;
  logic        video_sdram_resp_valid;
  logic [15:0] video_sdram_rdata;
  logic        video_sdram_ack;
  logic        pix_pop_i;
  logic [15:0] pix_data_o;
  logic        pix_empty_o;
  logic        underflow_o;
  logic        overrun_o;
`ifdef VIDEO_FETCH_STATS_EN
  logic [15:0] underflow_cnt_o;
`endif

  video_line_fetcher dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .line_start_i           (line_start_i),
    .line_base_i            (line_base_i),
    .busy_o                 (busy_o),
    .video_sdram_rd         (video_sdram_rd),
    .video_sdram_addr_x16   (video_sdram_addr_x16),
    .video_sdram_rdy        (video_sdram_rdy),
    .video_sdram_resp_valid (video_sdram_resp_valid),
    .video_sdram_rdata      (video_sdram_rdata),
    .video_sdram_ack        (video_sdram_ack),
    .pix_pop_i              (pix_pop_i),
    .pix_data_o             (pix_data_o),
    .pix_empty_o            (pix_empty_o),
    .underflow_o            (underflow_o),
    .overrun_o              (overrun_o)
`ifdef VIDEO_FETCH_STATS_EN
    ,
    .underflow_cnt_o        (underflow_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  localparam int BURSTS = 320 / 8;

  int          n_vec = 0;
  int          n_miscmp = 0;
  logic [15:0] exp_q[$];
  logic [23:0] exp_addr = '0;
  logic [23:0] last_rd_addr = '0;
  logic [23:0] pend_addr = '0;
  bit          pend_flag = 0;
  int          acks_line = 0;
  int          bursts_line = 0;
  bit          expect_idle = 0;
  bit          rd_prev = 0;
  bit          ack_prev = 0;
  bit          granted = 0;
  int          words_sent = 0;
  int          gdelay = 0;
  int          gmax = 0;
  bit          same_cycle = 0;
  bit          force_a5 = 0;
  int          pop_pct = 0;
  bit          force_pop = 0;
  int          n_under = 0;
  bit          start_req = 0;
  logic [23:0] start_base = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_word();
    logic [15:0] w;
    w = (force_a5 && words_sent == 0) ? 16'hA5A5 : 16'($urandom);
    force_a5 = 0;
    video_sdram_rdata      = w;
    video_sdram_resp_valid = 1'b1;
    exp_q.push_back(w);
    words_sent++;
  endtask

  // One cycle: sample at negedge, check against the model, then drive inputs for the next posedge.
  task automatic tick();
    logic [15:0] w;
    @(negedge clk_i);
    line_start_i           = 1'b0;
    pix_pop_i              = 1'b0;
    video_sdram_rdy        = 1'b0;
    video_sdram_resp_valid = 1'b0;

    if (expect_idle) begin
      check("busy_after_last_ack", busy_o, 1'b0);
      expect_idle = 0;
    end
    check("pix_empty", pix_empty_o, exp_q.size() == 0);
    if (video_sdram_rd && !rd_prev) begin
      check("burst_addr", video_sdram_addr_x16, exp_addr);
      check("space_before_req", exp_q.size() <= 56, 1'b1);
      last_rd_addr = video_sdram_addr_x16;
      bursts_line++;
    end else if (video_sdram_rd) begin
      check("addr_stable", video_sdram_addr_x16, last_rd_addr);
    end

    if (start_req) begin
      start_req    = 0;
      line_start_i = 1'b1;
      line_base_i  = start_base;
      if (!busy_o) begin
        exp_q.delete();
        exp_addr    = start_base;
        acks_line   = 0;
        bursts_line = 0;
      end else begin
        pend_flag = 1;
        pend_addr = start_base;
      end
    end else if (force_pop) begin
      pix_pop_i = 1'b1;
      check("pix_data_empty", pix_data_o, 16'h0000);
      n_under++;
    end else if (pop_pct > 0 && exp_q.size() > 0 && $urandom_range(1, 100) <= pop_pct) begin
      w = exp_q.pop_front();
      check("pix_data", pix_data_o, w);
      pix_pop_i = 1'b1;
    end

    if (video_sdram_ack) begin
      check("ack_width", ack_prev, 1'b0);
      check("rd_low_in_ack", video_sdram_rd, 1'b0);
      granted    = 0;
      words_sent = 0;
      gdelay     = $urandom_range(0, gmax);
      if (pend_flag) begin
        pend_flag   = 0;
        exp_q.delete();
        exp_addr    = pend_addr;
        acks_line   = 0;
        bursts_line = 0;
      end else begin
        acks_line++;
        exp_addr = exp_addr + 24'd8;
        if (acks_line == BURSTS) expect_idle = 1;
        else check("busy_mid_line", busy_o, 1'b1);
      end
    end

    if (video_sdram_rd && !granted) begin
      if (gdelay == 0) begin
        video_sdram_rdy = 1'b1;
        granted         = 1;
        if (same_cycle) send_word();
      end else begin
        gdelay--;
      end
    end else if (granted && words_sent < 8 && $urandom_range(0, 3) != 0) begin
      send_word();
    end

    rd_prev  = video_sdram_rd;
    ack_prev = video_sdram_ack;
  endtask

  task automatic start_line(input logic [23:0] base);
    start_req  = 1;
    start_base = base;
    tick();
    tick();
    check("busy_after_start", busy_o, 1'b1);
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (busy_o && n < budget);
    check("line_done_in_time", busy_o, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    pop_pct = 100;
    while (exp_q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    tick();
    check("drained_empty", pix_empty_o, 1'b1);
  endtask

  initial begin
    int n;
    rst_i = 1'b1;
    line_start_i = 1'b0;
    line_base_i = '0;
    video_sdram_rdy = 1'b0;
    video_sdram_resp_valid = 1'b0;
    video_sdram_rdata = '0;
    pix_pop_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_busy", busy_o, 1'b0);
    check("rst_rd", video_sdram_rd, 1'b0);
    check("rst_ack", video_sdram_ack, 1'b0);
    check("rst_addr", video_sdram_addr_x16, 24'h0);
    check("rst_empty", pix_empty_o, 1'b1);
    check("rst_data", pix_data_o, 16'h0);
    check("rst_underflow", underflow_o, 1'b0);
    check("rst_overrun", overrun_o, 1'b0);

    // Full line at 0x001000, rdy one cycle after rd, pixels popping randomly.
    gmax = 0; gdelay = 0; same_cycle = 0; pop_pct = 60;
    start_line(24'h001000);
    run_until_idle(5000);
    check("line1_acks", acks_line, BURSTS);
    check("line1_bursts", bursts_line, BURSTS);
    check("line1_last_addr", last_rd_addr, 24'h001138);
    drain();

    // No pops: FIFO fills to 64 words and the fetcher stalls; 8 pops release one more burst.
    gmax = 3; pop_pct = 0;
    start_line(24'h040000 + 24'($urandom_range(0, 255)));
    repeat (300) tick();
    check("stall_rd_low", video_sdram_rd, 1'b0);
    check("stall_busy", busy_o, 1'b1);
    check("stall_bursts", bursts_line, 8);
    check("stall_not_empty", pix_empty_o, 1'b0);
    pop_pct = 100;
    repeat (8) tick();
    pop_pct = 0;
    repeat (40) tick();
    check("resume_bursts", bursts_line, 9);
    check("resume_addr", last_rd_addr, start_base + 24'd64);
    pop_pct = 70;
    run_until_idle(5000);
    check("line2_acks", acks_line, BURSTS);
    drain();

    // rdy with the first word in the same cycle; base near the top of the address space wraps.
    same_cycle = 1; gmax = 2; pop_pct = 0; force_a5 = 1;
    start_line(24'hFFFFF8);
    n = 0;
    while (acks_line < 1 && n < 200) begin tick(); n++; end
    check("first_burst_acked", acks_line, 1);
    check("head_a5a5", pix_data_o, 16'hA5A5);
    n = 0;
    while (bursts_line < 2 && n < 200) begin tick(); n++; end
    check("wrap_addr", last_rd_addr, 24'h000000);
    pop_pct = 70;
    run_until_idle(5000);
    drain();

    // line_start_i mid-DATA: burst completes, FIFO flushes, restart at the new base.
    same_cycle = 0; pop_pct = 0;
    start_line(24'h300000);
    n = 0;
    while (!(granted && words_sent == 4) && n < 200) begin tick(); n++; end
    check("reach_mid_data", granted && words_sent == 4, 1'b1);
    start_req = 1;
    start_base = 24'h200000;
    n = 0;
    while ((pend_flag || start_req || bursts_line < 1) && n < 300) begin tick(); n++; end
    check("restart_addr", last_rd_addr, 24'h200000);
    check("overrun_set", overrun_o, 1'b1);
    pop_pct = 70;
    run_until_idle(5000);
    check("overrun_sticky", overrun_o, 1'b1);
    check("no_underflow_yet", underflow_o, 1'b0);
    drain();

    // Three pops on an empty FIFO.
    pop_pct = 0; force_pop = 1;
    repeat (3) tick();
    force_pop = 0;
    tick();
    check("underflow_set", underflow_o, 1'b1);
`ifdef VIDEO_FETCH_STATS_EN
    check("underflow_cnt", underflow_cnt_o, n_under);
`endif

    // New line from IDLE clears stickies; random base, timing and pop rate.
    gmax = 3; same_cycle = 1'($urandom_range(0, 1)); pop_pct = 50;
    start_line(24'($urandom));
    check("overrun_cleared", overrun_o, 1'b0);
    check("underflow_cleared", underflow_o, 1'b0);
    run_until_idle(5000);
    check("line_rand_acks", acks_line, BURSTS);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
